multi_alarm_clock: RTL and testbench

Parametrised timekeeping core: integrated 1 Hz divider, 24 h hour/minute/second counters, synchronous time load, and NUM_ALARMS independent alarm channels, each with enable, automatic ring timeout and snooze. It is the successor to the single-alarm clock path: it replaces the divider, clock counter and alarm compare stages under the top level. Its outputs feed the HEX/VGA display and the audio ring driver unchanged.

---
 rtl/multi_alarm_clock.sv | 216 +++++++++++++++++++++
 tb/tb_multi_alarm_clock.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 1 Hz divider, 24 h time counters with synchronous load,
// and NUM_ALARMS alarm channels with enable, ring timeout and snooze.
module multi_alarm_clock #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int NUM_ALARMS   = 4,
  parameter int RING_SECONDS = 30,
  parameter int SNOOZE_MIN   = 5,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CLK_50,
  input  logic                  reset_en,
  input  logic                  run_en,
  input  logic                  set_time_en,
  input  logic [5:0]            hour_set,
  input  logic [5:0]            minute_set,
  input  logic [5:0]            second_set,
  input  logic                  alarm_wr_en,
  input  logic [AW-1:0]         alarm_idx,
  input  logic                  alarm_on,
  input  logic [5:0]            alarm_hour,
  input  logic [5:0]            alarm_minute,
  input  logic [5:0]            alarm_second,
  input  logic                  ack,
  input  logic                  snooze,
  output logic [5:0]            hour,
  output logic [5:0]            minute,
  output logic [5:0]            second,
  output logic                  tick,
  output logic                  set_err,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  alarm_any,
  output logic [AW-1:0]         ring_idx
);

  localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_HZ - 1);
  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZED
  } ch_state_t;

  logic [DW-1:0] div_reg;
  logic [5:0]    hour_reg, minute_reg, second_reg;
  logic [5:0]    hour_next, minute_next, second_next;
  logic          tick_reg, set_err_reg;
  logic          div_wrap, time_ok, load_ok, alarm_ok, alarm_wr;
  logic [17:0]   cur_time, wake_time;
  logic [6:0]    wake_min_sum;
  logic [5:0]    wake_hour, wake_minute;
  logic [NUM_ALARMS-1:0] ringing_vec;
  logic [AW-1:0] ring_idx_next;

  assign div_wrap = run_en && (div_reg == DIV_MAX);
  assign time_ok  = (hour_set <= 6'd23) && (minute_set <= 6'd59) && (second_set <= 6'd59);
  assign load_ok  = set_time_en && time_ok;
  assign alarm_ok = (alarm_hour <= 6'd23) && (alarm_minute <= 6'd59) && (alarm_second <= 6'd59);
  assign alarm_wr = alarm_wr_en && alarm_ok;
  assign cur_time = {hour_reg, minute_reg, second_reg};

  // One-second increment of the current time with minute/hour carries and midnight wrap.
  always_comb begin
    hour_next   = hour_reg;
    minute_next = minute_reg;
    second_next = second_reg + 6'd1;
    if (second_reg == 6'd59) begin
      second_next = 6'd0;
      minute_next = minute_reg + 6'd1;
      if (minute_reg == 6'd59) begin
        minute_next = 6'd0;
        hour_next   = (hour_reg == 6'd23) ? 6'd0 : hour_reg + 6'd1;
      end
    end
  end

  // Snooze wake time: now plus SNOOZE_MIN minutes, seconds kept, wrapping at midnight.
  always_comb begin
    wake_min_sum = {1'b0, minute_reg} + 7'(SNOOZE_MIN);
    wake_minute  = wake_min_sum[5:0];
    wake_hour    = hour_reg;
    if (wake_min_sum >= 7'd60) begin
      wake_minute = 6'(wake_min_sum - 7'd60);
      wake_hour   = (hour_reg == 6'd23) ? 6'd0 : hour_reg + 6'd1;
    end
  end

  assign wake_time = {wake_hour, wake_minute, second_reg};

  // Divider, time counters, tick and set_err; a valid load overrides a same-cycle tick.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      div_reg     <= '0;
      hour_reg    <= 6'd0;
      minute_reg  <= 6'd0;
      second_reg  <= 6'd0;
      tick_reg    <= 1'b0;
      set_err_reg <= 1'b0;
    end else begin
      tick_reg    <= 1'b0;
      set_err_reg <= (set_time_en && !time_ok) || (alarm_wr_en && !alarm_ok);
      if (load_ok) begin
        hour_reg   <= hour_set;
        minute_reg <= minute_set;
        second_reg <= second_set;
        div_reg    <= '0;
      end else if (run_en) begin
        if (div_wrap) begin
          div_reg    <= '0;
          hour_reg   <= hour_next;
          minute_reg <= minute_next;
          second_reg <= second_next;
          tick_reg   <= 1'b1;
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
      ch_state_t   state_reg, state_next;
      logic        on_reg, on_next;
      logic [17:0] alarm_time_reg, alarm_time_next;
      logic [17:0] wake_reg, wake_next;
      logic [7:0]  cnt_reg, cnt_next;
      logic        wr_hit;

      assign wr_hit = alarm_wr && (alarm_idx == AW'(gi));

      // Channel next state: write, then ack, then snooze, then tick-driven match/timeout.
      // Matches are evaluated the cycle after a tick, against the freshly advanced time.
      always_comb begin
        state_next      = state_reg;
        on_next         = on_reg;
        alarm_time_next = alarm_time_reg;
        wake_next       = wake_reg;
        cnt_next        = cnt_reg;
        if (wr_hit) begin
          on_next         = alarm_on;
          alarm_time_next = {alarm_hour, alarm_minute, alarm_second};
          state_next      = ST_IDLE;
          cnt_next        = 8'd0;
        end else if (ack && (state_reg != ST_IDLE)) begin
          state_next = ST_IDLE;
        end else if (snooze && (state_reg == ST_RINGING)) begin
          state_next = ST_SNOOZED;
          wake_next  = wake_time;
        end else if (tick_reg) begin
          case (state_reg)
            ST_IDLE: begin
              if (on_reg && (alarm_time_reg == cur_time)) begin
                state_next = ST_RINGING;
                cnt_next   = 8'd0;
              end
            end
            ST_RINGING: begin
              cnt_next = cnt_reg + 8'd1;
              if (cnt_reg == RING_LAST) begin
                state_next = ST_IDLE;
              end
            end
            ST_SNOOZED: begin
              if (wake_reg == cur_time) begin
                state_next = ST_RINGING;
                cnt_next   = 8'd0;
              end
            end
            default: state_next = ST_IDLE;
          endcase
        end
      end

      // Channel state, stored alarm time, wake time and ring counter.
      always_ff @(posedge CLK_50 or negedge reset_en) begin
        if (!reset_en) begin
          state_reg      <= ST_IDLE;
          on_reg         <= 1'b0;
          alarm_time_reg <= 18'd0;
          wake_reg       <= 18'd0;
          cnt_reg        <= 8'd0;
        end else begin
          state_reg      <= state_next;
          on_reg         <= on_next;
          alarm_time_reg <= alarm_time_next;
          wake_reg       <= wake_next;
          cnt_reg        <= cnt_next;
        end
      end

      assign ringing_vec[gi] = (state_reg == ST_RINGING);
    end
  endgenerate

  // Lowest-index ringing channel; 0 when nothing rings.
  always_comb begin
    ring_idx_next = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ringing_vec[i]) begin
        ring_idx_next = AW'(i);
      end
    end
  end

  assign hour      = hour_reg;
  assign minute    = minute_reg;
  assign second    = second_reg;
  assign tick      = tick_reg;
  assign set_err   = set_err_reg;
  assign ringing   = ringing_vec;
  assign alarm_any = |ringing_vec;
  assign ring_idx  = ring_idx_next;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock: a seconds-of-day reference model
// pushes the expected outputs each clock; a monitor pops and compares them.
module tb_multi_alarm_clock;

  localparam int CLK_HZ = 4;
  localparam int NA     = 4;
  localparam int RS     = 3;
  localparam int SM     = 5;
  localparam int AW     = 2;
  localparam int DAY    = 86400;
  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic          clk;
  logic          reset_en, run_en, set_time_en;
  logic [5:0]    hour_set, minute_set, second_set;
  logic          alarm_wr_en;
  logic [AW-1:0] alarm_idx;
  logic          alarm_on;
  logic [5:0]    alarm_hour, alarm_minute, alarm_second;
  logic          ack, snooze;
  logic [5:0]    hour, minute, second;
  logic          tick, set_err;
  logic [NA-1:0] ringing;
  logic          alarm_any;
  logic [AW-1:0] ring_idx;

  multi_alarm_clock #(
    .CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .RING_SECONDS(RS), .SNOOZE_MIN(SM)
  ) dut (
    .CLK_50(clk), .reset_en(reset_en), .run_en(run_en), .set_time_en(set_time_en),
    .hour_set(hour_set), .minute_set(minute_set), .second_set(second_set),
    .alarm_wr_en(alarm_wr_en), .alarm_idx(alarm_idx), .alarm_on(alarm_on),
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_second(alarm_second),
    .ack(ack), .snooze(snooze),
    .hour(hour), .minute(minute), .second(second),
    .tick(tick), .set_err(set_err), .ringing(ringing),
    .alarm_any(alarm_any), .ring_idx(ring_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tod;
    bit tk;
    bit err;
    int ring;
    int ridx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: time as seconds of day, alarms as plain arrays.
  int m_tod, m_div;
  bit m_tick, m_err;
  int m_on[NA], m_at[NA], m_st[NA], m_cnt[NA], m_wake[NA];

  task automatic push_exp(bit flush);
    exp_t e;
    e.tod  = m_tod;
    e.tk   = m_tick;
    e.err  = m_err;
    e.ring = 0;
    e.ridx = 0;
    for (int i = NA - 1; i >= 0; i--) begin
      if (m_st[i] == M_RING) begin
        e.ring = e.ring | (1 << i);
        e.ridx = i;
      end
    end
    if (flush) exp_q.delete();
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    int  old_tod;
    bit  old_tick, t_ok, a_ok;
    if (!reset_en) begin
      m_tod = 0; m_div = 0; m_tick = 0; m_err = 0;
      for (int i = 0; i < NA; i++) begin
        m_on[i] = 0; m_at[i] = 0; m_st[i] = M_IDLE; m_cnt[i] = 0; m_wake[i] = 0;
      end
      push_exp(1'b1);
    end else begin
      old_tod  = m_tod;
      old_tick = m_tick;
      t_ok = (hour_set < 24) && (minute_set < 60) && (second_set < 60);
      a_ok = (alarm_hour < 24) && (alarm_minute < 60) && (alarm_second < 60);
      for (int i = 0; i < NA; i++) begin
        if (alarm_wr_en && a_ok && int'(alarm_idx) == i) begin
          m_on[i]  = alarm_on;
          m_at[i]  = alarm_hour * 3600 + alarm_minute * 60 + alarm_second;
          m_st[i]  = M_IDLE;
          m_cnt[i] = 0;
        end else if (ack && m_st[i] != M_IDLE) begin
          m_st[i] = M_IDLE;
        end else if (snooze && m_st[i] == M_RING) begin
          m_st[i]   = M_SNZ;
          m_wake[i] = (old_tod + SM * 60) % DAY;
        end else if (old_tick) begin
          if (m_st[i] == M_IDLE && m_on[i] != 0 && m_at[i] == old_tod) begin
            m_st[i] = M_RING; m_cnt[i] = 0;
          end else if (m_st[i] == M_RING) begin
            m_cnt[i]++;
            if (m_cnt[i] >= RS) m_st[i] = M_IDLE;
          end else if (m_st[i] == M_SNZ && m_wake[i] == old_tod) begin
            m_st[i] = M_RING; m_cnt[i] = 0;
          end
        end
      end
      m_err = (set_time_en && !t_ok) || (alarm_wr_en && !a_ok);
      if (set_time_en && t_ok) begin
        m_tod = hour_set * 3600 + minute_set * 60 + second_set;
        m_div = 0; m_tick = 0;
      end else if (run_en) begin
        if (m_div == CLK_HZ - 1) begin
          m_div = 0; m_tod = (m_tod + 1) % DAY; m_tick = 1;
        end else begin
          m_div++; m_tick = 0;
        end
      end else begin
        m_tick = 0;
      end
      push_exp(1'b0);
    end
  endtask

  // Model runs on every clock edge and on asynchronous reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge reset_en);
      model_step();
    end
  end

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty got=0 entries want=1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("hour",      int'(hour),      e.tod / 3600);
        chk("minute",    int'(minute),    (e.tod / 60) % 60);
        chk("second",    int'(second),    e.tod % 60);
        chk("tick",      int'(tick),      int'(e.tk));
        chk("set_err",   int'(set_err),   int'(e.err));
        chk("ringing",   int'(ringing),   e.ring);
        chk("alarm_any", int'(alarm_any), (e.ring != 0) ? 1 : 0);
        chk("ring_idx",  int'(ring_idx),  e.ridx);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int h, int m, int s);
    $display("txn load %0d:%0d:%0d", h, m, s);
    set_time_en = 1'b1;
    hour_set = 6'(h); minute_set = 6'(m); second_set = 6'(s);
    step();
    set_time_en = 1'b0;
  endtask

  task automatic awrite(int idx, bit on, int h, int m, int s);
    logic [7:0] idx_full;
    idx_full = 8'(idx);
    $display("txn alarm_write idx=%0d on=%0d %0d:%0d:%0d", idx, on, h, m, s);
    alarm_wr_en = 1'b1;
    alarm_idx = idx_full[AW-1:0];
    alarm_on = on;
    alarm_hour = 6'(h); alarm_minute = 6'(m); alarm_second = 6'(s);
    step();
    alarm_wr_en = 1'b0;
  endtask

  task automatic pulse(bit do_ack, bit do_snz);
    $display("txn strobe ack=%0d snooze=%0d", do_ack, do_snz);
    ack = do_ack; snooze = do_snz;
    step();
    ack = 1'b0; snooze = 1'b0;
  endtask

  task automatic wait_state(int ch, int want, int budget);
    int n = 0;
    while (m_st[ch] != want && n < budget) begin
      step();
      n++;
    end
    total++;
    if (m_st[ch] != want) begin
      bad++;
      $display("FAIL wait_state ch=%0d got=%0d want=%0d (timeout)", ch, m_st[ch], want);
    end
  endtask

  initial begin
    int r, t;
    reset_en = 1'b0; run_en = 1'b0; set_time_en = 1'b0;
    hour_set = '0; minute_set = '0; second_set = '0;
    alarm_wr_en = 1'b0; alarm_idx = '0; alarm_on = 1'b0;
    alarm_hour = '0; alarm_minute = '0; alarm_second = '0;
    ack = 1'b0; snooze = 1'b0;

    repeat (3) step();
    reset_en = 1'b1;
    step();
    run_en = 1'b1;
    repeat (13) step();
    run_en = 1'b0;
    repeat (5) step();
    run_en = 1'b1;

    // Midnight rollover and rejected loads.
    load(23, 59, 58);
    repeat (12) step();
    load(24, 0, 0);
    step();
    load(12, 60, 0);
    repeat (3) step();

    // Load on the same cycle as the divider terminal count.
    for (int i = 0; i < 8 && m_div != CLK_HZ - 1; i++) step();
    load(1, 2, 3);
    repeat (6) step();

    // Alarm 2 rings at 00:00:05 and times out after RS ticks.
    awrite(2, 1'b1, 0, 0, 5);
    awrite(1, 1'b1, 0, 61, 0);
    load(0, 0, 4);
    wait_state(2, M_RING, 40);
    repeat (20) step();

    // Snooze from 07:00:10 and from 23:58:00 (wraps past midnight).
    awrite(0, 1'b1, 7, 0, 10);
    load(7, 0, 9);
    wait_state(0, M_RING, 40);
    pulse(1'b0, 1'b1);
    wait_state(0, M_RING, 1400);
    step();
    pulse(1'b1, 1'b0);
    awrite(0, 1'b1, 23, 58, 0);
    load(23, 57, 59);
    wait_state(0, M_RING, 40);
    pulse(1'b0, 1'b1);
    wait_state(0, M_RING, 1400);
    pulse(1'b1, 1'b0);

    // Two channels at once; ack and snooze together.
    awrite(0, 1'b0, 0, 0, 0);
    awrite(1, 1'b1, 10, 0, 1);
    awrite(3, 1'b1, 10, 0, 1);
    load(10, 0, 0);
    wait_state(1, M_RING, 40);
    step();
    pulse(1'b1, 1'b1);
    repeat (4) step();

    // Asynchronous reset mid-ring.
    awrite(1, 1'b1, 11, 0, 1);
    load(11, 0, 0);
    wait_state(1, M_RING, 40);
    $display("txn async_reset");
    reset_en = 1'b0;
    step();
    step();
    reset_en = 1'b1;
    step();

    // Index 5 truncates to channel 1.
    awrite(5, 1'b1, 0, 0, 3);
    load(0, 0, 2);
    wait_state(1, M_RING, 40);
    pulse(1'b1, 1'b0);

    // Randomised phase.
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        load($urandom_range(0, 25), $urandom_range(0, 61), $urandom_range(0, 61));
      end else if (r < 7) begin
        t = (m_tod + $urandom_range(1, 8)) % DAY;
        if ($urandom_range(0, 9) == 0)
          awrite($urandom_range(0, 3), 1'b1, t / 3600, (t / 60) % 60, 60 + $urandom_range(0, 3));
        else
          awrite($urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), t / 3600, (t / 60) % 60, t % 60);
      end else if (r < 9) begin
        pulse(1'b1, 1'b0);
      end else if (r < 12) begin
        pulse(1'b0, 1'b1);
      end else if (r < 13) begin
        run_en = ~run_en;
        step();
      end else begin
        step();
      end
    end
    run_en = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
